// File: rtl/vdec_hs_enc.sv
// vdec_hs_enc: HS-SCCH part1/part2 and E-AGCH encoder (CC1/3, UE mask, puncturing)
// that packs 6-bit sign-magnitude soft samples into 24-bit DIRAM words.
`default_nettype none

module vdec_hs_derm (
  input  logic [1:0] hs_mode,
  input  logic [6:0] code_index,
  output logic       punc
);

  always_comb begin
    punc = 1'b0;
    case (hs_mode)
      2'b00:   punc = code_index inside {7'd0, 7'd1, 7'd3, 7'd7, 7'd41, 7'd44, 7'd46, 7'd47};
      // part2 drops the g2 symbol of bits 0..30 (111 -> 80), agch drops every g2 (90 -> 60)
      2'b01:   punc = (code_index < 7'd93) && ((code_index % 7'd3) == 7'd2);
      2'b10:   punc = ((code_index % 7'd3) == 7'd2);
      default: punc = 1'b0;
    endcase
  end

endmodule

module vdec_hs_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [28:0] info_bits,
  input  logic [5:0]  codeblk_size_p7,
  input  logic [1:0]  hs_mode,
  input  logic [15:0] ue_mask,
  input  logic [8:0]  base_sys,
  input  logic [4:0]  amp,
  output logic        diram_wr_req,
  input  logic        diram_wr_ack,
  output logic [8:0]  diram_waddr,
  output logic [23:0] diram_wdata,
  output logic [6:0]  sym_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  bit_index;
  logic [1:0]  phase;
  logic [6:0]  code_index;
  logic [7:0]  cc_reg;
  logic [7:0]  mask_reg;
  logic [5:0]  cbs;
  logic [1:0]  mode;
  logic [15:0] mask_cfg;
  logic [4:0]  amp_cfg;
  logic [8:0]  addr;
  logic [23:0] word;
  logic [1:0]  lane_cnt;
  logic        last;

  logic        cc_in;
  logic        g0;
  logic        g1;
  logic        g2;
  logic        mask_in;
  logic        h0;
  logic        h1;
  logic        mask_bit;
  logic        gsel;
  logic        sym;
  logic [5:0]  sample;
  logic [23:0] word_next;
  logic        last_sym;
  logic        punc;

  vdec_hs_derm u_derm (
    .hs_mode    (mode),
    .code_index (code_index),
    .punc       (punc)
  );

  assign busy = start | (state != IDLE);

  assign cc_in = (bit_index <= 6'd28) ? info_bits[bit_index[4:0]] : 1'b0;
  assign g0    = cc_reg[7] ^ cc_reg[6] ^ cc_reg[5] ^ cc_reg[4] ^ cc_reg[2] ^ cc_reg[1] ^ cc_in;
  assign g1    = cc_reg[7] ^ cc_reg[6] ^ cc_reg[3] ^ cc_reg[2] ^ cc_reg[0] ^ cc_in;
  assign g2    = cc_reg[7] ^ cc_reg[4] ^ cc_reg[1] ^ cc_reg[0] ^ cc_in;

  // The mask encoder sees each UE-id bit for two code indices, then shifts.
  assign mask_in  = (code_index[6:1] <= 6'd15) ? mask_cfg[code_index[4:1]] : 1'b0;
  assign h0       = mask_reg[7] ^ mask_reg[3] ^ mask_reg[2] ^ mask_reg[1] ^ mask_in;
  assign h1       = mask_reg[7] ^ mask_reg[6] ^ mask_reg[4] ^ mask_reg[2] ^ mask_reg[1] ^
                    mask_reg[0] ^ mask_in;
  assign mask_bit = (mode == 2'b00) ? (code_index[0] ? h0 : h1) : 1'b0;

  assign gsel     = (phase == 2'd0) ? g0 : ((phase == 2'd1) ? g1 : g2);
  assign sym      = gsel ^ mask_bit;
  assign sample   = {sym, amp_cfg};
  assign last_sym = (bit_index == cbs) && (phase == 2'd2);

  always_comb begin
    word_next = word;
    case (lane_cnt)
      2'd0:    word_next[23:18] = sample;
      2'd1:    word_next[5:0]   = sample;
      2'd2:    word_next[11:6]  = sample;
      default: word_next[17:12] = sample;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_index    <= 6'd0;
      phase        <= 2'd0;
      code_index   <= 7'd0;
      cc_reg       <= 8'd0;
      mask_reg     <= 8'd0;
      cbs          <= 6'd0;
      mode         <= 2'd0;
      mask_cfg     <= 16'd0;
      amp_cfg      <= 5'd0;
      addr         <= 9'd0;
      word         <= 24'd0;
      lane_cnt     <= 2'd0;
      last         <= 1'b0;
      done         <= 1'b0;
      diram_wr_req <= 1'b0;
      diram_waddr  <= 9'd0;
      diram_wdata  <= 24'd0;
      sym_cnt      <= 7'd0;
    end else if (start) begin
      // start also aborts a run in progress; a pending write is dropped
      state        <= ENC;
      bit_index    <= 6'd0;
      phase        <= 2'd0;
      code_index   <= 7'd0;
      cc_reg       <= 8'd0;
      mask_reg     <= 8'd0;
      cbs          <= codeblk_size_p7;
      mode         <= hs_mode;
      mask_cfg     <= ue_mask;
      amp_cfg      <= amp;
      addr         <= base_sys;
      word         <= 24'd0;
      lane_cnt     <= 2'd0;
      last         <= 1'b0;
      done         <= 1'b0;
      diram_wr_req <= 1'b0;
      sym_cnt      <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
        end
        ENC: begin
          code_index <= code_index + 7'd1;
          if (phase == 2'd2) begin
            phase     <= 2'd0;
            bit_index <= bit_index + 6'd1;
            cc_reg    <= {cc_in, cc_reg[7:1]};
          end else begin
            phase <= phase + 2'd1;
          end
          if (code_index[0]) begin
            mask_reg <= {mask_in, mask_reg[7:1]};
          end
          if (!punc) begin
            sym_cnt  <= sym_cnt + 7'd1;
            lane_cnt <= lane_cnt + 2'd1;
          end
          if (!punc && (lane_cnt == 2'd3)) begin
            diram_wdata  <= word_next;
            diram_waddr  <= addr;
            diram_wr_req <= 1'b1;
            word         <= 24'd0;
            last         <= last_sym;
            state        <= WR;
          end else if (last_sym) begin
            if (!punc || (lane_cnt != 2'd0)) begin
              // partial final word; untouched lanes are still zero
              diram_wdata  <= punc ? word : word_next;
              diram_waddr  <= addr;
              diram_wr_req <= 1'b1;
              word         <= 24'd0;
              lane_cnt     <= 2'd0;
              last         <= 1'b1;
              state        <= WR;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (!punc) begin
            word <= word_next;
          end
        end
        WR: begin
          if (diram_wr_ack) begin
            diram_wr_req <= 1'b0;
            addr         <= addr + 9'd1;
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ENC;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vdec_hs_enc.sv
// tb_vdec_hs_enc: directed runs of vdec_hs_enc with hand-computed and
// convolution-model expected DIRAM words.
`default_nettype none

module tb_vdec_hs_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [28:0] info_bits = 29'd0;
  logic [5:0]  codeblk_size_p7 = 6'd15;
  logic [1:0]  hs_mode = 2'b00;
  logic [15:0] ue_mask = 16'd0;
  logic [8:0]  base_sys = 9'd0;
  logic [4:0]  amp = 5'd31;
  logic        diram_wr_req;
  logic        diram_wr_ack = 1'b0;
  logic [8:0]  diram_waddr;
  logic [23:0] diram_wdata;
  logic [6:0]  sym_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  logic [23:0] exp_w [0:31];
  int          n_w;
  int          n_sym;

  // tap sets as delay bitmaps: bit d set means input delayed by d is XORed in
  localparam logic [8:0] G0 = 9'h0DF;
  localparam logic [8:0] G1 = 9'h167;
  localparam logic [8:0] G2 = 9'h193;
  localparam logic [8:0] H0 = 9'h0E3;
  localparam logic [8:0] H1 = 9'h1D7;

  vdec_hs_enc dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .info_bits       (info_bits),
    .codeblk_size_p7 (codeblk_size_p7),
    .hs_mode         (hs_mode),
    .ue_mask         (ue_mask),
    .base_sys        (base_sys),
    .amp             (amp),
    .diram_wr_req    (diram_wr_req),
    .diram_wr_ack    (diram_wr_ack),
    .diram_waddr     (diram_waddr),
    .diram_wdata     (diram_wdata),
    .sym_cnt         (sym_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tapx(input logic [63:0] seq, input int k, input logic [8:0] taps);
    logic x = 1'b0;
    for (int d = 0; d < 9; d++)
      if (taps[d] && (k - d) >= 0) x ^= seq[k - d];
    return x;
  endfunction

  function automatic logic is_punc(input logic [1:0] mode, input int ci, input int b, input int p);
    case (mode)
      2'b00:   return (ci == 0) || (ci == 1) || (ci == 3) || (ci == 7) ||
                      (ci == 41) || (ci == 44) || (ci == 46) || (ci == 47);
      2'b01:   return (p == 2) && (b <= 30);
      2'b10:   return (p == 2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic void build_model(input logic [1:0] mode, input int cbs, input logic [28:0] info,
                                      input logic [15:0] mask, input logic [4:0] a);
    logic [63:0] s_in;
    logic [63:0] s_m;
    logic [23:0] wd;
    logic [5:0]  smp;
    logic        g;
    logic        m;
    int          ci;
    int          lane;
    s_in = {35'd0, info};
    s_m  = {48'd0, mask};
    wd = 24'd0; ci = 0; lane = 0; n_w = 0; n_sym = 0;
    for (int b = 0; b <= cbs; b++) begin
      for (int p = 0; p < 3; p++) begin
        g = tapx(s_in, b, (p == 0) ? G0 : ((p == 1) ? G1 : G2));
        m = (mode == 2'b00) ? tapx(s_m, ci / 2, (ci % 2 == 1) ? H0 : H1) : 1'b0;
        if (!is_punc(mode, ci, b, p)) begin
          smp = {g ^ m, a};
          case (lane)
            0:       wd[23:18] = smp;
            1:       wd[5:0]   = smp;
            2:       wd[11:6]  = smp;
            default: wd[17:12] = smp;
          endcase
          lane++; n_sym++;
          if (lane == 4) begin
            exp_w[n_w] = wd; n_w++; wd = 24'd0; lane = 0;
          end
        end
        ci++;
      end
    end
    if (lane > 0) begin
      exp_w[n_w] = wd; n_w++;
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic setup(input logic [1:0] mode, input logic [28:0] info, input logic [15:0] mask,
                       input logic [8:0] base, input logic [4:0] a);
    hs_mode = mode; info_bits = info; ue_mask = mask; base_sys = base; amp = a;
    codeblk_size_p7 = (mode == 2'b00) ? 6'd15 : ((mode == 2'b01) ? 6'd36 : 6'd29);
  endtask

  task automatic run_check(input string tag, input int maxdly);
    int t;
    int dly;
    int d0;
    logic stable;
    logic [8:0] exp_a;
    d0 = done_seen;
    start = 1'b1; step(); start = 1'b0;
    check({tag, " req after start"}, {31'd0, diram_wr_req}, 32'd0);
    check({tag, " busy after start"}, {31'd0, busy}, 32'd1);
    for (int w = 0; w < n_w; w++) begin
      t = 0;
      while (!diram_wr_req && t < 100) begin step(); t++; end
      if (!diram_wr_req) begin
        check({tag, " req timeout"}, 32'd0, 32'd1);
        return;
      end
      exp_a = base_sys + w[8:0];
      check({tag, " addr"}, {23'd0, diram_waddr}, {23'd0, exp_a});
      check({tag, " data"}, {8'd0, diram_wdata}, {8'd0, exp_w[w]});
      dly = $urandom_range(maxdly, 0);
      stable = 1'b1;
      repeat (dly) begin
        step();
        if (diram_wr_req !== 1'b1 || diram_waddr !== exp_a || diram_wdata !== exp_w[w]) stable = 1'b0;
      end
      if (dly > 0) check({tag, " req stable"}, {31'd0, stable}, 32'd1);
      diram_wr_ack = 1'b1; step(); diram_wr_ack = 1'b0;
      check({tag, " req drop"}, {31'd0, diram_wr_req}, 32'd0);
    end
    t = 0;
    while (!done && t < 10) begin step(); t++; end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " sym_cnt"}, {25'd0, sym_cnt}, n_sym);
    step();
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    check({tag, " sym_cnt hold"}, {25'd0, sym_cnt}, n_sym);
    check({tag, " one done"}, done_seen - d0, 32'd1);
  endtask

  initial begin
    int d0;
    step(); step();
    check("reset req", {31'd0, diram_wr_req}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset sym_cnt", {25'd0, sym_cnt}, 32'd0);
    check("reset waddr", {23'd0, diram_waddr}, 32'd0);
    check("reset wdata", {8'd0, diram_wdata}, 32'd0);
    rst = 1'b0; step();

    // all-zero part1: every sample is {0, 31}
    setup(2'b00, 29'd0, 16'd0, 9'd0, 5'd31);
    for (int i = 0; i < 10; i++) exp_w[i] = 24'h7DF7DF;
    n_w = 10; n_sym = 40;
    run_check("p1 zero", 0);

    // agch impulse: hand-traced g0/g1 impulse response, g2 punctured
    setup(2'b10, 29'd1, 16'd0, 9'd3, 5'd31);
    exp_w[0] = 24'hFFFFFF; exp_w[1] = 24'hFDFFFF; exp_w[2] = 24'hFFF7DF;
    exp_w[3] = 24'hFDFFFF; exp_w[4] = 24'h7DF7FF;
    for (int i = 5; i < 15; i++) exp_w[i] = 24'h7DF7DF;
    n_w = 15; n_sym = 60;
    run_check("agch impulse", 2);

    for (int r = 0; r < 3; r++) begin
      setup(2'b00, {21'd0, 8'($urandom)}, 16'($urandom), 9'($urandom), 5'($urandom));
      build_model(hs_mode, codeblk_size_p7, info_bits, ue_mask, amp);
      run_check("p1 rand", 7);
    end

    setup(2'b01, 29'($urandom), 16'd0, 9'd505, 5'd17);
    build_model(hs_mode, codeblk_size_p7, info_bits, ue_mask, amp);
    check("p2 words", n_w, 32'd20);
    run_check("p2 wrap", 3);

    setup(2'b10, {7'd0, 22'($urandom)}, 16'd0, 9'd40, 5'd0);
    build_model(hs_mode, codeblk_size_p7, info_bits, ue_mask, amp);
    run_check("agch amp0", 1);

    // abort a part2 run while its first write is pending
    setup(2'b01, 29'($urandom), 16'd0, 9'd100, 5'd9);
    build_model(hs_mode, codeblk_size_p7, info_bits, ue_mask, amp);
    d0 = done_seen;
    start = 1'b1; step(); start = 1'b0;
    repeat (20) step();
    check("abort req pending", {31'd0, diram_wr_req}, 32'd1);
    run_check("abort rerun", 2);
    check("abort done count", done_seen - d0, 32'd1);

    // reset mid-run
    setup(2'b10, 29'h155, 16'd0, 9'd7, 5'd5);
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();
    #2 rst = 1'b1; #1;
    check("rst req", {31'd0, diram_wr_req}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst sym_cnt", {25'd0, sym_cnt}, 32'd0);
    check("rst wdata", {8'd0, diram_wdata}, 32'd0);
    step(); rst = 1'b0; step();
    build_model(hs_mode, codeblk_size_p7, info_bits, ue_mask, amp);
    run_check("after rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
